// File: rtl/product_accum_buffer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | product_accum_buffer                                                       |
// | Per-lane saturating accumulator of product tiles with a one-deep           |
// | output buffer and a HOLD state for backpressure.                           |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module product_accum_buffer #(
    parameter int DIM_C     = 4,
    parameter int DIM_A     = 4,
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               mode,
    input  logic [CNT_WIDTH-1:0]               acc_len,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DIM_C*DIM_A*IN_WIDTH-1:0]    in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DIM_C*DIM_A*ACC_WIDTH-1:0]   out_data,
    output logic [DIM_C*DIM_A-1:0]             out_sat
);

    localparam int LANES = DIM_C * DIM_A;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                     state;
    logic [CNT_WIDTH-1:0]       cnt;
    logic [CNT_WIDTH-1:0]       tile_len;
    logic [CNT_WIDTH-1:0]       first_len;
    logic [LANES*ACC_WIDTH-1:0] acc;
    logic [LANES*ACC_WIDTH-1:0] in_ext;
    logic [LANES*ACC_WIDTH-1:0] acc_sum;
    logic [LANES-1:0]           sat;
    logic [LANES-1:0]           clamp;
    logic                       buf_free;
    logic                       last_beat;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic signed [IN_WIDTH-1:0]  lane_in;
            logic signed [ACC_WIDTH-1:0] lane_ext;
            logic        [ACC_WIDTH:0]   wide;

            assign lane_in  = in_data[k*IN_WIDTH +: IN_WIDTH];
            assign lane_ext = ACC_WIDTH'(lane_in);
            // One guard bit: overflow shows up as disagreement of the top two bits.
            assign wide     = {acc[(k+1)*ACC_WIDTH-1], acc[k*ACC_WIDTH +: ACC_WIDTH]}
                            + {lane_ext[ACC_WIDTH-1], lane_ext};
            assign clamp[k] = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
            assign in_ext[k*ACC_WIDTH +: ACC_WIDTH]  = lane_ext;
            assign acc_sum[k*ACC_WIDTH +: ACC_WIDTH] = !clamp[k] ? wide[ACC_WIDTH-1:0]
                                                     : (wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX);
        end
    endgenerate

    assign in_ready  = (state != S_HOLD);
    assign buf_free  = !out_valid || out_ready;
    assign first_len = (!mode || acc_len == '0) ? CNT_WIDTH'(1) : acc_len;
    assign last_beat = (cnt + 1'b1) == tile_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tile_len  <= '0;
            acc       <= '0;
            sat       <= '0;
            out_data  <= '0;
            out_sat   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        tile_len <= first_len;
                        sat      <= '0;
                        if (first_len == CNT_WIDTH'(1)) begin
                            cnt <= '0;
                            if (buf_free) begin
                                out_data  <= in_ext;
                                out_sat   <= '0;
                                out_valid <= 1'b1;
                            end else begin
                                acc   <= in_ext;
                                state <= S_HOLD;
                            end
                        end else begin
                            acc   <= in_ext;
                            cnt   <= CNT_WIDTH'(1);
                            state <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        if (last_beat) begin
                            cnt <= '0;
                            if (buf_free) begin
                                out_data  <= acc_sum;
                                out_sat   <= sat | clamp;
                                out_valid <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                acc   <= acc_sum;
                                sat   <= sat | clamp;
                                state <= S_HOLD;
                            end
                        end else begin
                            acc <= acc_sum;
                            sat <= sat | clamp;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    // Only reachable with out_valid set, so out_ready alone means a transfer.
                    if (out_ready) begin
                        out_data  <= acc;
                        out_sat   <= sat;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_product_accum_buffer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_product_accum_buffer                                                    |
// | Randomized and directed bench against a transaction-level tile model.      |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_product_accum_buffer;

    localparam int DC = 2;
    localparam int DA = 3;
    localparam int IW = 16;
    localparam int AW = 20;
    localparam int CW = 5;
    localparam int N  = DC * DA;
    localparam longint AMAX = (64'sd1 <<< (AW-1)) - 64'sd1;
    localparam longint AMIN = -(64'sd1 <<< (AW-1));

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mode = 1'b0;
    logic [CW-1:0]   acc_len = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*IW-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [N*AW-1:0] out_data;
    logic [N-1:0]    out_sat;

    product_accum_buffer #(
        .DIM_C(DC), .DIM_A(DA), .IN_WIDTH(IW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .acc_len(acc_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: running sums of the open tile plus a queue of finished tiles
    // (front = what the consumer sees, at most one more waiting behind it).
    longint          part [N];
    bit [N-1:0]      psat;
    int              pcnt;
    int              plen;
    bit              pact;
    logic [N*AW-1:0] qd[$];
    logic [N-1:0]    qs[$];

    function automatic logic [N*AW-1:0] pack_part();
        logic [N*AW-1:0] r;
        longint v;
        for (int k = 0; k < N; k++) begin
            v = part[k];
            r[k*AW +: AW] = v[AW-1:0];
        end
        return r;
    endfunction

    function automatic logic [N*IW-1:0] fill(input int v);
        logic [N*IW-1:0] r;
        for (int k = 0; k < N; k++) r[k*IW +: IW] = IW'(v);
        return r;
    endfunction

    task automatic model_reset();
        qd.delete();
        qs.delete();
        pact = 1'b0;
        pcnt = 0;
    endtask

    task automatic cycle(input bit v, input bit m, input logic [CW-1:0] len,
                         input logic [N*IW-1:0] d, input bit ordy);
        bit fo, fi;
        longint x;
        check("out_valid", 128'(out_valid), 128'(qd.size() > 0));
        if (qd.size() > 0) begin
            check("out_data", 128'(out_data), 128'(qd[0]));
            check("out_sat", 128'(out_sat), 128'(qs[0]));
        end
        check("in_ready", 128'(in_ready), 128'(qd.size() < 2));
        in_valid  = v;
        mode      = m;
        acc_len   = len;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        fo = (qd.size() > 0) && ordy;
        fi = v && (qd.size() < 2);
        if (fo) begin
            void'(qd.pop_front());
            void'(qs.pop_front());
        end
        if (fi) begin
            if (!pact) begin
                plen = !m ? 1 : ((len == 0) ? 1 : int'(len));
                for (int k = 0; k < N; k++) part[k] = 0;
                psat = '0;
                pcnt = 0;
                pact = 1'b1;
            end
            for (int k = 0; k < N; k++) begin
                x = longint'($signed(d[k*IW +: IW]));
                part[k] = part[k] + x;
                if (part[k] > AMAX) begin part[k] = AMAX; psat[k] = 1'b1; end
                if (part[k] < AMIN) begin part[k] = AMIN; psat[k] = 1'b1; end
            end
            pcnt++;
            if (pcnt == plen) begin
                qd.push_back(pack_part());
                qs.push_back(psat);
                pact = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_out_sat", 128'(out_sat), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N*IW-1:0] d;
        logic [CW-1:0]   len;
        model_reset();
        repeat (2) @(negedge clk);
        check("init_out_valid", 128'(out_valid), 128'(0));
        check("init_out_data", 128'(out_data), 128'(0));
        check("init_in_ready", 128'(in_ready), 128'(1));
        rst_n = 1'b1;

        // Load mode pass-through, one tile per cycle.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 5'd3, fill(5), 1'b1);
        idle(2);

        // Accumulate four beats on lane 0: 1+2+3-10.
        d = fill(0);
        d[IW-1:0] = 16'd1;      cycle(1'b1, 1'b1, 5'd4, d, 1'b1);
        d[IW-1:0] = 16'd2;      cycle(1'b1, 1'b0, 5'd9, d, 1'b1);
        d[IW-1:0] = 16'd3;      cycle(1'b1, 1'b1, 5'd1, d, 1'b1);
        d[IW-1:0] = 16'hFFF6;   cycle(1'b1, 1'b1, 5'd4, d, 1'b1);
        check("acc4_lane0", 128'(out_data[AW-1:0]), 128'(20'hFFFFC));
        idle(2);

        // Positive and negative saturation over 17 extreme beats.
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b1, 5'd17, fill(32'h7FFF), 1'b1);
        check("sat_pos_data", 128'(out_data[AW-1:0]), 128'(20'h7FFFF));
        check("sat_pos_flag", 128'(out_sat), 128'({N{1'b1}}));
        idle(1);
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b1, 5'd17, fill(32'h8000), 1'b1);
        check("sat_neg_data", 128'(out_data[AW-1:0]), 128'(20'h80000));
        idle(2);

        // Backpressure: two single-beat tiles with a stalled consumer.
        cycle(1'b1, 1'b0, 5'd0, fill(7), 1'b0);
        cycle(1'b1, 1'b0, 5'd0, fill(9), 1'b0);
        cycle(1'b1, 1'b0, 5'd0, fill(11), 1'b0);
        check("hold_in_ready", 128'(in_ready), 128'(0));
        check("hold_data", 128'(out_data[AW-1:0]), 128'(7));
        cycle(1'b0, 1'b0, 5'd0, '0, 1'b1);
        check("hold_next", 128'(out_data[AW-1:0]), 128'(9));
        idle(3);

        // acc_len of zero means one beat; then reset in the middle of a tile.
        cycle(1'b1, 1'b1, 5'd0, fill(12), 1'b1);
        cycle(1'b1, 1'b1, 5'd4, fill(1), 1'b1);
        cycle(1'b1, 1'b1, 5'd4, fill(1), 1'b1);
        do_reset();
        cycle(1'b1, 1'b0, 5'd0, fill(3), 1'b1);
        check("post_rst_data", 128'(out_data[AW-1:0]), 128'(3));
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < N; k++) begin
                case ($urandom_range(0, 5))
                    0: d[k*IW +: IW] = 16'h7FFF;
                    1: d[k*IW +: IW] = 16'h8000;
                    default: d[k*IW +: IW] = IW'($urandom);
                endcase
            end
            len = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(16, 31)) : CW'($urandom_range(0, 4));
            cycle($urandom_range(0, 3) != 0, 1'($urandom), len, d, $urandom_range(0, 9) < 7);
            if (i == 300) do_reset();
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
